uart_transceiver: RTL and testbench

- Parametrised full-duplex UART: one transmitter and one receiver sharing a single clock domain.
- Generalises the fixed 9N1 TX/RX pair to configurable data width, parity mode, stop-bit count and bit period.
- Adds a false-start filter, a parity-error flag and break handling.
- Sits between system logic (send/ready, done pulse) and the serial pins.

---
 rtl/uart_transceiver.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver.sv
// uart_transceiver: parametrised full-duplex UART (one TX, one RX, one clock).
// Frame: start(0), DATA_BITS payload LSB first, optional parity, stop bit(s).
// The RX path adds a 2-flop synchroniser, a false-start filter, a parity-error
// flag and break handling. It also reports framing errors.
// Optional build macro UART_LOOPBACK_EN adds a 'loopback' input. When
// loopback is high, internal tx feeds the receiver and the tx pin is held high.
module uart_transceiver #(
  parameter int DATA_BITS    = 9,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_tx,
  output logic                 tx,
  output logic                 ready,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_rx,
  output logic                 done,
  output logic                 framing_error,
  output logic                 parity_error
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]     DATA_END = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_END = 4'(STOP_BITS - 1);
  localparam logic [1:0]     PAR_MODE = 2'(PARITY);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  // Parity bit that goes with a payload: even mode gives an even total
  // count of ones, odd mode gives an odd total.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d,
                                     input logic [1:0]           mode);
    logic p;
    p = ^d;
    case (mode)
      2'd1:    parity_of = p;
      2'd2:    parity_of = ~p;
      default: parity_of = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------- TX ----
  state_e                 tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;

  // TX next-state logic; the serial bit and ready are decoded from the next state so both stay registered
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      ST_IDLE: begin
        if (send && ready_q) begin
          tx_shift_d = data_tx;
          tx_par_d   = parity_of(data_tx, PAR_MODE);
          tx_cnt_d   = '0;
          tx_bit_d   = 4'd0;
          tx_state_d = ST_START;
        end else begin
          tx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 4'd0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d   = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          if (tx_bit_q == DATA_END) begin
            tx_bit_d   = 4'd0;
            tx_state_d = (PAR_MODE != 2'd0) ? ST_PARITY : ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d   = tx_cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 4'd0;
          tx_state_d = ST_STOP;
        end else begin
          tx_cnt_d   = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == STOP_END) begin
            tx_bit_d   = 4'd0;
            tx_state_d = ST_IDLE;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d   = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_bit_d   = 4'd0;
        tx_state_d = ST_IDLE;
      end
    endcase

    case (tx_state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = tx_shift_d[0];
      ST_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
    ready_d = (tx_state_d == ST_IDLE);
  end

  // TX state and output registers; reset forces the line idle-high at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
    end
  end

  assign ready = ready_q;

  // ---------------------------------------------------------------- RX ----
  logic rx_in_s;
`ifdef UART_LOOPBACK_EN
  assign rx_in_s = loopback ? tx_q : rx;
  assign tx      = loopback ? 1'b1 : tx_q;
`else
  assign rx_in_s = rx;
  assign tx      = tx_q;
`endif

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  state_e               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] data_rx_q, data_rx_d;
  logic                 done_q, done_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in_s;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX next-state logic: half-bit start qualification, mid-bit sampling, stop/break handling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    data_rx_d  = data_rx_q;
    done_d     = 1'b0;
    fe_d       = 1'b0;
    pe_d       = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = ST_START;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = 4'd0;
          if (rx_sync_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_END) begin
            rx_bit_d   = 4'd0;
            rx_state_d = (PAR_MODE != 2'd0) ? ST_PARITY : ST_STOP;
          end else begin
            rx_bit_d   = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = ST_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            data_rx_d  = rx_shift_q;
            done_d     = 1'b1;
            pe_d       = (PAR_MODE != 2'd0) &&
                         (rx_par_q != parity_of(rx_shift_q, PAR_MODE));
            rx_state_d = ST_IDLE;
          end else begin
            fe_d       = 1'b1;
            rx_state_d = ST_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        rx_cnt_d = '0;
        if (rx_sync_q) begin
          rx_state_d = ST_IDLE;
        end else begin
          rx_state_d = ST_BREAK;
        end
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  // RX state, received-data and status-pulse registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      data_rx_q  <= '0;
      done_q     <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      data_rx_q  <= data_rx_d;
      done_q     <= done_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
    end
  end

  assign data_rx       = data_rx_q;
  assign done          = done_q;
  assign framing_error = fe_q;
  assign parity_error  = pe_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: a default 9N1 instance and an 8E2 instance.
module tb_uart_transceiver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       send = 1'b0, send_p = 1'b0;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic [8:0] data_tx = 9'h000;
  logic [7:0] data_tx_p = 8'h00;
  logic       tx, ready, done, fe, pe;
  logic [8:0] data_rx;
  logic       tx_p, ready_p, done_p, fe_p, pe_p;
  logic [7:0] data_rx_p;

  int passes = 0, fails = 0, total = 0;
  int cyc = 0;
  int done_cnt = 0, fe_cnt = 0, pe_cnt = 0, done_cyc = 0;
  int done_p_cnt = 0, fe_p_cnt = 0, pe_with_done = 0, pe_alone = 0;

  always #5 clock = ~clock;

  uart_transceiver dut (
    .clock(clock), .reset(reset), .send(send), .data_tx(data_tx),
    .tx(tx), .ready(ready),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx(rx), .data_rx(data_rx), .done(done),
    .framing_error(fe), .parity_error(pe)
  );

  uart_transceiver #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(2)) dut_p (
    .clock(clock), .reset(reset), .send(send_p), .data_tx(data_tx_p),
    .tx(tx_p), .ready(ready_p),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx(rx_p), .data_rx(data_rx_p), .done(done_p),
    .framing_error(fe_p), .parity_error(pe_p)
  );

  // Cycle counter and pulse monitors for both instances
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (fe) fe_cnt <= fe_cnt + 1;
    if (pe) pe_cnt <= pe_cnt + 1;
    if (done_p) done_p_cnt <= done_p_cnt + 1;
    if (fe_p) fe_p_cnt <= fe_p_cnt + 1;
    if (pe_p && done_p) pe_with_done <= pe_with_done + 1;
    if (pe_p && !done_p) pe_alone <= pe_alone + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one frame and check the tx bit at each mid-bit point plus the ready-low length
  task automatic tx_run(input bit which, input logic [8:0] d, input logic [11:0] frame,
                        input int nbits, input int exp_low);
    int low;
    @(negedge clock);
    if (which) begin send_p = 1'b1; data_tx_p = d[7:0]; end
    else begin send = 1'b1; data_tx = d; end
    @(negedge clock);
    send = 1'b0; send_p = 1'b0;
    low = 0;
    for (int n = 1; n <= exp_low + 20; n++) begin
      if (!(which ? ready_p : ready)) low++;
      if (n == 1) check("tx_start_low_after_accept", which ? tx_p : tx, 1'b0);
      if ((n % 16) == 8 && (n / 16) < nbits) check("tx_bit", which ? tx_p : tx, frame[n / 16]);
      if (n == exp_low + 1) check("ready_rise", which ? ready_p : ready, 1'b1);
      @(negedge clock);
    end
    check("ready_low_cycles", low, exp_low);
  endtask

  // Drive a serial frame (bit 0 first) onto rx or rx_p, then leave the line at end_level
  task automatic rx_frame(input bit which, input logic [11:0] bits, input int nbits,
                          input logic end_level);
    for (int i = 0; i < nbits; i++) begin
      if (which) rx_p = bits[i]; else rx = bits[i];
      repeat (16) @(negedge clock);
    end
    if (which) rx_p = end_level; else rx = end_level;
  endtask

  initial begin
    int d0, f0, start_cyc, dp0, pw0, delta;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_data_rx", data_rx, 9'h000);
    check("rst_done", done, 1'b0);
    check("rst_fe", fe, 1'b0);
    check("rst_pe", pe, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // TX 9'h1A5, 9N1: frame bits {stop, data, start} = 11'h74A, 176 cycles busy
    tx_run(1'b0, 9'h1A5, 12'h74A, 11, 176);

    // RX 9'h0F3 with correct timing
    d0 = done_cnt; f0 = fe_cnt;
    start_cyc = cyc;
    rx_frame(1'b0, {1'b0, 1'b1, 9'h0F3, 1'b0}, 11, 1'b1);
    repeat (20) @(negedge clock);
    check("rx_done_once", done_cnt - d0, 1);
    check("rx_data", data_rx, 9'h0F3);
    check("rx_no_fe", fe_cnt - f0, 0);
    delta = done_cyc - start_cyc;
    check("rx_done_in_stop_bit", (delta >= 166 && delta <= 176), 1'b1);

    // Stop bit low, line held low 400 more cycles: one framing error, data kept
    d0 = done_cnt; f0 = fe_cnt;
    rx_frame(1'b0, {1'b0, 1'b0, 9'h155, 1'b0}, 11, 1'b0);
    repeat (400) @(negedge clock);
    rx = 1'b1;
    repeat (20) @(negedge clock);
    check("break_one_fe", fe_cnt - f0, 1);
    check("break_no_done", done_cnt - d0, 0);
    check("break_data_kept", data_rx, 9'h0F3);
    d0 = done_cnt;
    rx_frame(1'b0, {1'b0, 1'b1, 9'h0AA, 1'b0}, 11, 1'b1);
    repeat (20) @(negedge clock);
    check("after_break_done", done_cnt - d0, 1);
    check("after_break_data", data_rx, 9'h0AA);

    // 5-cycle low glitch is rejected, then a normal frame still works
    d0 = done_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_fe", fe_cnt - f0, 0);
    check("glitch_data_kept", data_rx, 9'h0AA);
    rx_frame(1'b0, {1'b0, 1'b1, 9'h1C3, 1'b0}, 11, 1'b1);
    repeat (20) @(negedge clock);
    check("post_glitch_done", done_cnt - d0, 1);
    check("post_glitch_data", data_rx, 9'h1C3);
    check("no_parity_err_when_none", pe_cnt, 0);

    // 8E2: data 8'h07 (three ones) with parity bit 0 -> mismatch flagged with done
    dp0 = done_p_cnt; pw0 = pe_with_done;
    rx_frame(1'b1, {2'b11, 1'b0, 8'h07, 1'b0}, 12, 1'b1);
    repeat (20) @(negedge clock);
    check("par_bad_done", done_p_cnt - dp0, 1);
    check("par_bad_pe_with_done", pe_with_done - pw0, 1);
    check("par_bad_data", data_rx_p, 8'h07);
    // Correct parity bit 1 -> done without parity error
    dp0 = done_p_cnt; pw0 = pe_with_done;
    rx_frame(1'b1, {2'b11, 1'b1, 8'h07, 1'b0}, 12, 1'b1);
    repeat (20) @(negedge clock);
    check("par_ok_done", done_p_cnt - dp0, 1);
    check("par_ok_no_pe", pe_with_done - pw0, 0);
    check("pe_never_alone", pe_alone, 0);
    check("par_no_fe", fe_p_cnt, 0);
    // 8E2 TX of 8'h07: 12'hE0E frame, 192 cycles busy
    tx_run(1'b1, 9'h007, 12'hE0E, 12, 192);

    // Reset in the middle of data bit 4 of a 9'h1A5 frame
    @(negedge clock);
    send = 1'b1; data_tx = 9'h1A5;
    @(negedge clock);
    send = 1'b0;
    repeat (71) @(negedge clock);
    check("tx_bit4_before_reset", tx, 1'b0);
    check("ready_before_reset", ready, 1'b0);
    reset = 1'b0;
    #1;
    check("reset_tx_high", tx, 1'b1);
    check("reset_ready_high", ready, 1'b1);
    check("reset_data_rx_cleared", data_rx, 9'h000);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("post_reset_tx_idle", tx, 1'b1);
    // Clean frame after release: 9'h0F0 -> 11'h5E0
    tx_run(1'b0, 9'h0F0, 12'h5E0, 11, 176);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
